xu_wb_scheduler: RTL and testbench
==================================

# xu_wb_scheduler

Issue/writeback scheduler for the execute stage's fixed-latency units (bypass, adder, logical, shifter, branch, memory). It accepts one instruction per cycle, reserves the single register-file writeback slot at the cycle the selected unit's result emerges, and pulses that unit's start strobe. It stalls issue on slot collisions and, optionally, on RAW hazards. It then drives the writeback mux select, destination register and write enable in the exact cycle each result is valid.

## Interface
- MAX_LAT, 3: reservation depth in cycles; must be ≥ every entry of XU_LAT.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- issue_valid  in  1  an instruction is offered.
- issue_ready  out  1  the offered instruction is accepted this cycle (combinational).
- issue_xu  in  xu_t (3)  target execution unit.
- issue_rd  in  5  destination register.
- issue_we  in  1  instruction writes rd.
- issue_rs1, issue_rs2  in  5 each  source registers (used only with hazard checking).
- flush  in  1  synchronous kill of all pending reservations.
- unit_start  out  NUM_XU  one-hot start strobe to the selected unit; asserted in the accept cycle.
- wb_valid  out  1  a result is at the unit outputs this cycle.
- wb_sel  out  NUM_XU  one-hot writeback mux select.
- wb_rd  out  5  writeback destination.
- wb_we  out  1  register-file write enable (wb_valid & entry we & rd≠0).
- busy  out  1  any slot valid.

## Operation
- State: ring slot[0..MAX_LAT-1], each {valid, xu, rd, we}. The writeback outputs decode slot[0] combinationally.
- Accept: acc = issue_valid & issue_ready. Then L = XU_LAT[issue_xu].
- issue_ready = !flush & !collide & !hazard, where collide = (L<MAX_LAT) & slot[L].valid.
- Every edge:
  - slot[i] <= slot[i+1] for i<MAX_LAT-1.
  - slot[MAX_LAT-1] <= empty.
  - If acc, slot[L-1] <= {1, issue_xu, issue_rd, issue_we}. The no-collision rule guarantees this slot was empty.
- unit_start[issue_xu] = acc. All other bits are 0.
- flush: all slots are cleared at the edge. issue_ready=0 in the flush cycle. wb_* still reflect slot[0] during that cycle.
- issue_ready may depend combinationally on issue_xu/rs*. The producer must hold its offer stable until it is accepted.
- Unknown or out-of-range issue_xu: treated as XU_BYPASS latency. A simulation assertion flags it.

## Timing
- Reset (async, reset=0): all slots are invalid.
  - wb_valid=0, wb_we=0, wb_sel=0, wb_rd=0.
  - unit_start=0, busy=0.
  - issue_ready=0 while reset is asserted.
- Accept in cycle t with latency L: wb_valid=1 in cycle t+L with that entry's rd/sel. This matches a unit that captures its operands at edge t+1 and is L stages deep (e.g. bypass DEPTH=3 → wb at t+3).
- Throughput is one per cycle when latencies do not collide.
  - Example: SHIFTER (2) at t followed by ADDER (1) at t+1 collides, because both target t+2.
  - The ADDER stalls one cycle and is accepted at t+2.
- A longer-latency accept in cycle t never blocks a shorter one at t+1 unless their target cycles coincide.
- Reset mid-operation discards all slots immediately. No wb strobe occurs after reset deasserts until a new accept.

## Configuration
- HAZARD_EN defined:
  - hazard = 1 when issue_rs1 or issue_rs2 (≠0) equals rd of any valid slot with we=1, including slot[0].
  - Issue stalls until the matching entry has retired.
- HAZARD_EN undefined:
  - hazard is tied to 0.
  - issue_rs1/rs2 are ignored; operand forwarding is the responsibility of the producer.

## Structure
- Shared package holds:
  - xu_t enum: XU_BYPASS, XU_ADDER, XU_LOGICAL, XU_SHIFTER, XU_BRANCH, XU_MEMORY.
  - NUM_XU = 6.
  - XU_LAT constant array: 3, 1, 1, 2, 1, 3.
  - wb_slot_t struct.
- One sub-module, wb_reservation_ring: the slot shift register, insert port and slot-valid vector. The top level keeps the ready/hazard logic and the decoders.

## Test plan
- Reset then a single BYPASS issue, rd=5, we=1, at cycle 10 → unit_start[BYPASS] in cycle 10; wb_valid, wb_we, wb_rd=5, wb_sel=BYPASS in cycle 13 only; busy 11–13.
- Back-to-back ADDER rd=1,2,3 in cycles 0–2 → all accepted; wb in cycles 1,2,3 with rd 1,2,3.
- SHIFTER at cycle 0, then ADDER offered at cycle 1 → issue_ready=0 in cycle 1; ADDER accepted in cycle 2; wb rd order SHIFTER@2, ADDER@3.
- MEMORY rd=7 at cycle 0, flush in cycle 1 → no wb_valid in cycles 2–4; issue_ready=0 in cycle 1, 1 in cycle 2.
- HAZARD_EN: ADDER rd=4 at cycle 0, then LOGICAL rs1=4 offered at cycle 1 → stalled in cycle 1, accepted in cycle 2. Without the macro → accepted in cycle 1.
- ADDER rd=0, we=1 → wb_valid=1, wb_we=0. Async reset pulse asserted mid-flight with 3 slots valid → all outputs 0 immediately; no later wb.

Source files
------------

// File: rtl/xu_wb_scheduler_pkg.sv
// rtl/xu_wb_scheduler_pkg.sv - shared types and latency table for the execute-stage writeback scheduler
package xu_wb_scheduler_pkg;

  typedef enum logic [2:0] {
    XU_BYPASS  = 3'd0,
    XU_ADDER   = 3'd1,
    XU_LOGICAL = 3'd2,
    XU_SHIFTER = 3'd3,
    XU_BRANCH  = 3'd4,
    XU_MEMORY  = 3'd5
  } xu_t;

  localparam int NUM_XU = 6;

  localparam int XU_LAT [NUM_XU] = '{3, 1, 1, 2, 1, 3};

  typedef struct packed {
    logic       valid;
    xu_t        xu;
    logic [4:0] rd;
    logic       we;
  } wb_slot_t;

  localparam int SLOT_W = $bits(wb_slot_t);

  // Encodings past the last unit fall back to the bypass unit.
  function automatic xu_t xu_sanitize(input logic [2:0] x);
    return (x < 3'(NUM_XU)) ? xu_t'(x) : XU_BYPASS;
  endfunction

endpackage

// File: rtl/wb_reservation_ring.sv
// rtl/wb_reservation_ring.sv - writeback slot shift register with one-hot insert port
module wb_reservation_ring
  import xu_wb_scheduler_pkg::*;
#(
  parameter int MAX_LAT = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic [MAX_LAT-1:0]        ins_sel,
  input  logic [SLOT_W-1:0]         ins_slot,
  output logic [MAX_LAT*SLOT_W-1:0] slots,
  output logic [MAX_LAT-1:0]        slot_valid
);

  wb_slot_t [MAX_LAT-1:0] slot_q;
  wb_slot_t [MAX_LAT-1:0] slot_d;

  always_comb begin
    slot_d = '0;
    for (int i = 0; i < MAX_LAT - 1; i++) begin
      slot_d[i] = slot_q[i + 1];
    end
    // Insert lands one slot below its final target because the shift happens on the same edge.
    for (int i = 0; i < MAX_LAT; i++) begin
      if (ins_sel[i]) begin
        slot_d[i] = wb_slot_t'(ins_slot);
      end
    end
    if (flush) begin
      slot_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      slot_q <= '0;
    end else begin
      slot_q <= slot_d;
    end
  end

  always_comb begin
    slot_valid = '0;
    for (int i = 0; i < MAX_LAT; i++) begin
      slot_valid[i] = slot_q[i].valid;
    end
  end

  assign slots = slot_q;

endmodule

// File: rtl/xu_wb_scheduler.sv
// rtl/xu_wb_scheduler.sv - issue/writeback slot scheduler for fixed-latency execute units
// Optional RAW hazard stall enabled by defining HAZARD_EN.
module xu_wb_scheduler
  import xu_wb_scheduler_pkg::*;
#(
  parameter int MAX_LAT = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              issue_valid,
  output logic              issue_ready,
  input  logic [2:0]        issue_xu,
  input  logic [4:0]        issue_rd,
  input  logic              issue_we,
  input  logic [4:0]        issue_rs1,
  input  logic [4:0]        issue_rs2,
  input  logic              flush,
  output logic [NUM_XU-1:0] unit_start,
  output logic              wb_valid,
  output logic [NUM_XU-1:0] wb_sel,
  output logic [4:0]        wb_rd,
  output logic              wb_we,
  output logic              busy
);

  wb_slot_t [MAX_LAT-1:0] slots;
  logic [MAX_LAT-1:0]     slot_valid;
  logic [MAX_LAT-1:0]     ins_sel;
  wb_slot_t               ins_slot;
  xu_t                    xu_eff;
  int                     lat;
  logic                   collide;
  logic                   hazard;
  logic                   acc;
  logic                   unused_ok;

  wb_reservation_ring #(
    .MAX_LAT (MAX_LAT)
  ) u_ring (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .ins_sel    (ins_sel),
    .ins_slot   (ins_slot),
    .slots      (slots),
    .slot_valid (slot_valid)
  );

  always_comb begin
    xu_eff  = xu_sanitize(issue_xu);
    lat     = XU_LAT[xu_eff];
    collide = 1'b0;
    for (int i = 0; i < MAX_LAT; i++) begin
      if (lat == i && slot_valid[i]) begin
        collide = 1'b1;
      end
    end
    hazard = 1'b0;
`ifdef HAZARD_EN
    // slot[0] is still checked: its result is only written at the end of this cycle.
    for (int i = 0; i < MAX_LAT; i++) begin
      if (slots[i].valid && slots[i].we &&
          ((issue_rs1 != 5'd0 && issue_rs1 == slots[i].rd) ||
           (issue_rs2 != 5'd0 && issue_rs2 == slots[i].rd))) begin
        hazard = 1'b1;
      end
    end
`endif
    issue_ready = reset && !flush && !collide && !hazard;
    acc         = issue_valid && issue_ready;

    unit_start = '0;
    if (acc) begin
      unit_start[xu_eff] = 1'b1;
    end
    ins_sel = '0;
    for (int i = 0; i < MAX_LAT; i++) begin
      if (acc && lat == i + 1) begin
        ins_sel[i] = 1'b1;
      end
    end
    ins_slot.valid = 1'b1;
    ins_slot.xu    = xu_eff;
    ins_slot.rd    = issue_rd;
    ins_slot.we    = issue_we;
  end

  always_comb begin
    wb_valid = slots[0].valid;
    wb_sel   = '0;
    wb_rd    = 5'd0;
    if (slots[0].valid) begin
      wb_sel[slots[0].xu] = 1'b1;
      wb_rd               = slots[0].rd;
    end
    wb_we = slots[0].valid && slots[0].we && (slots[0].rd != 5'd0);
    busy  = |slot_valid;
  end

  assign unused_ok = ^{slots, issue_rs1, issue_rs2};

`ifndef SYNTHESIS
  a_xu_range : assert property (@(posedge clk) disable iff (!reset)
    issue_valid |-> (issue_xu < 3'(NUM_XU)));
`endif

endmodule

// File: tb/tb_xu_wb_scheduler.sv
// tb/tb_xu_wb_scheduler.sv - table-driven bench with writeback scoreboard for xu_wb_scheduler
module tb_xu_wb_scheduler;

  localparam logic [2:0] BYP = 3'd0, ADD = 3'd1, LOG = 3'd2, SHF = 3'd3, BR = 3'd4, MEM = 3'd5;
  localparam int LAT_TB [6] = '{3, 1, 1, 2, 1, 3};

  typedef struct {
    logic       valid;
    logic [2:0] xu;
    logic [4:0] rd;
    logic       we;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       flush;
    logic [1:0] rdy;   // 0/1 expected issue_ready, 2 = not checked
  } vec_t;

  typedef struct {
    int         tgt;
    logic [2:0] xu;
    logic [4:0] rd;
    logic       we;
  } sb_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       issue_valid = 1'b0;
  logic       issue_we = 1'b0;
  logic       flush = 1'b0;
  logic [2:0] issue_xu = 3'd0;
  logic [4:0] issue_rd = 5'd0;
  logic [4:0] issue_rs1 = 5'd0;
  logic [4:0] issue_rs2 = 5'd0;
  logic       issue_ready, wb_valid, wb_we, busy;
  logic [5:0] unit_start, wb_sel;
  logic [4:0] wb_rd;

  vec_t vecs[$];
  sb_t  sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  xu_wb_scheduler #(.MAX_LAT(3)) dut (
    .clk         (clk),
    .reset       (reset),
    .issue_valid (issue_valid),
    .issue_ready (issue_ready),
    .issue_xu    (issue_xu),
    .issue_rd    (issue_rd),
    .issue_we    (issue_we),
    .issue_rs1   (issue_rs1),
    .issue_rs2   (issue_rs2),
    .flush       (flush),
    .unit_start  (unit_start),
    .wb_valid    (wb_valid),
    .wb_sel      (wb_sel),
    .wb_rd       (wb_rd),
    .wb_we       (wb_we),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic void add(input logic v, input logic [2:0] xu, input logic [4:0] rd,
                              input logic we, input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic fl, input logic [1:0] rdy);
    vec_t e;
    e.valid = v; e.xu = xu; e.rd = rd; e.we = we;
    e.rs1 = rs1; e.rs2 = rs2; e.flush = fl; e.rdy = rdy;
    vecs.push_back(e);
  endfunction

  function automatic void idle(input int n, input logic [1:0] rdy);
    for (int k = 0; k < n; k++) add(1'b0, ADD, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0, rdy);
  endfunction

  task automatic check_cycle(input vec_t v);
    int         idx;
    bit         exp_acc;
    logic [5:0] exp_start;
    sb_t        e;
    idx = -1;
    foreach (sb[i]) if (sb[i].tgt == cyc) idx = i;
    chk("busy", 32'(busy), 32'(sb.size() != 0));
    if (idx >= 0) begin
      e = sb[idx];
      chk("wb_valid", 32'(wb_valid), 32'd1);
      chk("wb_sel", 32'(wb_sel), 32'(6'b1 << e.xu));
      chk("wb_rd", 32'(wb_rd), 32'(e.rd));
      chk("wb_we", 32'(wb_we), 32'(e.we && e.rd != 5'd0));
      sb.delete(idx);
    end else begin
      chk("wb_idle_valid", 32'(wb_valid), 32'd0);
      chk("wb_idle_we", 32'(wb_we), 32'd0);
    end
    if (v.rdy != 2'd2) chk("issue_ready", 32'(issue_ready), 32'(v.rdy[0]));
    exp_acc   = v.valid && v.rdy == 2'd1;
    exp_start = exp_acc ? (6'b1 << v.xu) : 6'b0;
    chk("unit_start", 32'(unit_start), 32'(exp_start));
    if (exp_acc) begin
      e.tgt = cyc + LAT_TB[v.xu]; e.xu = v.xu; e.rd = v.rd; e.we = v.we;
      sb.push_back(e);
    end
    if (v.flush) sb.delete();
  endtask

  task automatic run_vec(input vec_t v);
    issue_valid = v.valid; issue_xu = v.xu; issue_rd = v.rd; issue_we = v.we;
    issue_rs1 = v.rs1; issue_rs2 = v.rs2; flush = v.flush;
    @(negedge clk);
    check_cycle(v);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ready"}, 32'(issue_ready), 32'd0);
    chk({tag, "_wb_valid"}, 32'(wb_valid), 32'd0);
    chk({tag, "_wb_we"}, 32'(wb_we), 32'd0);
    chk({tag, "_wb_sel"}, 32'(wb_sel), 32'd0);
    chk({tag, "_wb_rd"}, 32'(wb_rd), 32'd0);
    chk({tag, "_start"}, 32'(unit_start), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cycle=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t iv;
    idle(10, 1);
    add(1, BYP, 5, 1, 0, 0, 0, 1);
    idle(4, 2);
    add(1, ADD, 1, 1, 0, 0, 0, 1);
    add(1, ADD, 2, 1, 0, 0, 0, 1);
    add(1, ADD, 3, 1, 0, 0, 0, 1);
    idle(2, 2);
    add(1, SHF, 8, 1, 0, 0, 0, 1);
    add(1, ADD, 9, 1, 0, 0, 0, 0);
    add(1, ADD, 9, 1, 0, 0, 0, 1);
    idle(2, 2);
    add(1, MEM, 7, 1, 0, 0, 0, 1);
    add(0, ADD, 0, 0, 0, 0, 1, 0);
    idle(4, 1);
`ifdef HAZARD_EN
    add(1, ADD, 4, 1, 0, 0, 0, 1);
    add(1, LOG, 10, 1, 4, 0, 0, 0);
    add(1, LOG, 10, 1, 4, 0, 0, 1);
    idle(2, 2);
`else
    add(1, ADD, 4, 1, 0, 0, 0, 1);
    add(1, LOG, 10, 1, 4, 0, 0, 1);
    idle(3, 2);
`endif
    add(1, ADD, 0, 1, 0, 0, 0, 1);
    add(1, LOG, 15, 1, 0, 0, 0, 1);
    idle(2, 2);
    add(1, BYP, 11, 1, 0, 0, 0, 1);
    add(1, ADD, 12, 1, 0, 0, 0, 1);
    idle(3, 2);
    add(1, ADD, 13, 0, 0, 0, 0, 1);
    add(1, BR, 0, 0, 0, 13, 0, 1);
    idle(2, 2);
`ifdef HAZARD_EN
    add(1, ADD, 14, 1, 0, 0, 0, 1);
    add(1, BR, 0, 0, 0, 14, 0, 0);
    add(1, BR, 0, 0, 0, 14, 0, 1);
    idle(3, 2);
`else
    add(1, ADD, 14, 1, 0, 0, 0, 1);
    add(1, BR, 0, 0, 0, 14, 0, 1);
    idle(4, 2);
`endif
    add(1, BYP, 20, 1, 0, 0, 0, 1);
    add(1, BYP, 21, 1, 0, 0, 0, 1);
    add(1, BYP, 22, 1, 0, 0, 0, 1);

    #1 reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_all_zero("por");
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    cyc = 0;

    foreach (vecs[i]) run_vec(vecs[i]);

    chk("busy_before_reset", 32'(busy), 32'(sb.size() != 0));
    issue_valid = 1'b0;
    reset = 1'b0;
    sb.delete();
    #1;
    check_all_zero("midrst");
    @(posedge clk);
    #1;
    reset = 1'b1;
    iv.valid = 1'b0; iv.xu = ADD; iv.rd = 5'd0; iv.we = 1'b0;
    iv.rs1 = 5'd0; iv.rs2 = 5'd0; iv.flush = 1'b0; iv.rdy = 2'd1;
    for (int k = 0; k < 6; k++) run_vec(iv);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
